// File: rtl/vga_txt_writer.sv
// Terminal-style writer for the VGA text buffer: keeps a cursor, decodes CR/LF/BS/FF,
// wraps lines and clears rows through the buffer write port only.
module vga_txt_writer #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 25,
    parameter int unsigned ADDR_W = 11,
    parameter logic [7:0]  FILL   = 8'h20
) (
    input  logic              i_clk,
    input  logic              i_rst_h,
    input  logic [7:0]        i_char_d,
    input  logic              i_char_valid_h,
    output logic              o_char_ready_h,
    output logic [7:0]        o_d_we,
    output logic [ADDR_W-1:0] o_addr_we,
    output logic              o_we_en_h,
    output logic              o_busy_h,
    output logic [6:0]        o_cur_x,
    output logic [4:0]        o_cur_y
);

    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] COLS_M1_A = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(COLS * ROWS - 1);
    localparam logic [6:0]        LAST_X    = 7'(COLS - 1);
    localparam logic [4:0]        LAST_Y    = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        S_CLR_ALL,
        S_IDLE,
        S_WR,
        S_WAIT,
        S_CLR_LINE
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          x_q, x_d;
    logic [4:0]          y_q, y_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [7:0]          data_q, data_d;
    logic                bs_q, bs_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          dout_q, dout_d;
    logic                rdy_q, rdy_d;
    logic                busy_q, busy_d;

    logic [4:0]          y_adv;
    logic [ADDR_W-1:0]   base_adv;

    // Next row and its base address; the bottom row wraps to row 0 (no scroll).
    always_comb begin
        y_adv    = (y_q == LAST_Y) ? 5'd0 : y_q + 5'd1;
        base_adv = (y_q == LAST_Y) ? '0 : base_q + COLS_A;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        bs_d    = bs_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdy_d   = 1'b0;
        busy_d  = 1'b1;

        case (state_q)
            S_CLR_ALL: begin
                // After reset the first write (address 0) has not been issued yet, so hold.
                if (we_q) begin
                    if (cnt_q == LAST_A) begin
                        state_d = S_IDLE;
                        x_d     = 7'd0;
                        y_d     = 5'd0;
                        base_d  = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            S_IDLE: begin
                if (rdy_q && i_char_valid_h) begin
                    case (i_char_d)
                        8'h0A: begin
                            x_d     = 7'd0;
                            y_d     = y_adv;
                            base_d  = base_adv;
                            cnt_d   = base_adv;
                            state_d = S_CLR_LINE;
                        end
                        8'h0D: begin
                            x_d     = 7'd0;
                            state_d = S_WAIT;
                        end
                        8'h08: begin
                            if (x_q != 7'd0) begin
                                x_d     = x_q - 7'd1;
                                data_d  = FILL;
                                bs_d    = 1'b1;
                                state_d = S_WR;
                            end else begin
                                state_d = S_WAIT;
                            end
                        end
                        8'h0C: begin
                            cnt_d   = '0;
                            state_d = S_CLR_ALL;
                        end
                        default: begin
                            if (i_char_d < 8'h20) begin
                                state_d = S_WAIT;
                            end else begin
                                data_d  = i_char_d;
                                bs_d    = 1'b0;
                                state_d = S_WR;
                            end
                        end
                    endcase
                end
            end
            S_WR: begin
                if (bs_q) begin
                    state_d = S_IDLE;
                end else if (x_q < LAST_X) begin
                    x_d     = x_q + 7'd1;
                    state_d = S_IDLE;
                end else begin
                    x_d     = 7'd0;
                    y_d     = y_adv;
                    base_d  = base_adv;
                    cnt_d   = base_adv;
                    state_d = S_CLR_LINE;
                end
            end
            S_WAIT: begin
                state_d = S_IDLE;
            end
            S_CLR_LINE: begin
                if (cnt_q == base_q + COLS_M1_A) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_CLR_ALL;
            end
        endcase

        // Registered outputs present the behaviour of the state being entered.
        rdy_d  = (state_d == S_IDLE);
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_WR: begin
                we_d   = 1'b1;
                addr_d = base_d + ADDR_W'(x_d);
                dout_d = data_d;
            end
            S_CLR_ALL, S_CLR_LINE: begin
                we_d   = 1'b1;
                addr_d = cnt_d;
                dout_d = FILL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_h) begin
            state_q <= S_CLR_ALL;
            x_q     <= 7'd0;
            y_q     <= 5'd0;
            base_q  <= '0;
            cnt_q   <= '0;
            data_q  <= 8'd0;
            bs_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= 8'd0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            bs_q    <= bs_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign o_char_ready_h = rdy_q;
    assign o_busy_h       = busy_q;
    assign o_we_en_h      = we_q;
    assign o_addr_we      = addr_q;
    assign o_d_we         = dout_q;
    assign o_cur_x        = x_q;
    assign o_cur_y        = y_q;

endmodule

// File: tb/tb_vga_txt_writer.sv
// Bench for vga_txt_writer: directed table, corner sequences and random characters
// checked against a screen-level model of the terminal rules.
module tb_vga_txt_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int TOTAL = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ch  = 8'd0;
    logic        vld = 1'b0;
    logic        o_char_ready_h, o_we_en_h, o_busy_h;
    logic [7:0]  o_d_we;
    logic [10:0] o_addr_we;
    logic [6:0]  o_cur_x;
    logic [4:0]  o_cur_y;

    vga_txt_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(11), .FILL(8'h20)) dut (
        .i_clk          (clk),
        .i_rst_h        (rst),
        .i_char_d       (ch),
        .i_char_valid_h (vld),
        .o_char_ready_h (o_char_ready_h),
        .o_d_we         (o_d_we),
        .o_addr_we      (o_addr_we),
        .o_we_en_h      (o_we_en_h),
        .o_busy_h       (o_busy_h),
        .o_cur_x        (o_cur_x),
        .o_cur_y        (o_cur_y)
    );

    always #5 clk = ~clk;

    typedef struct { int a; int d; int c; } wr_t;
    typedef struct { logic [7:0] ch; int ex; int ey; int nwr; int fa; int fd; } vec_t;

    wr_t  wq[$];
    wr_t  eq[$];
    vec_t vt[10];
    int   cyc = 0;
    int   viol = 0;
    int   pass_n = 0;
    int   tot_n = 0;
    int   mx = 0;
    int   my = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log plus protocol invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (o_we_en_h) wq.push_back('{int'(o_addr_we), int'(o_d_we), cyc});
        if (o_we_en_h && o_char_ready_h) viol++;
        if (o_busy_h !== ~o_char_ready_h) viol++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic void push(input int a, input int d, input int off);
        eq.push_back('{a, d, off});
    endfunction

    // Screen-level reference: expected writes (address, data, cycle offset from accept).
    function automatic void model(input logic [7:0] c, output int busy);
        eq.delete();
        busy = 1;
        if (c == 8'h0A) begin
            mx = 0;
            my = (my == ROWS - 1) ? 0 : my + 1;
            for (int i = 0; i < COLS; i++) push(my * COLS + i, 32, i);
            busy = COLS;
        end else if (c == 8'h0D) begin
            mx = 0;
        end else if (c == 8'h08) begin
            if (mx > 0) begin
                mx--;
                push(my * COLS + mx, 32, 0);
            end
        end else if (c == 8'h0C) begin
            for (int i = 0; i < TOTAL; i++) push(i, 32, i);
            mx = 0;
            my = 0;
            busy = TOTAL;
        end else if (c >= 8'h20) begin
            push(my * COLS + mx, int'(c), 0);
            if (mx < COLS - 1) begin
                mx++;
            end else begin
                mx = 0;
                my = (my == ROWS - 1) ? 0 : my + 1;
                for (int i = 0; i < COLS; i++) push(my * COLS + i, 32, i + 1);
                busy = COLS + 1;
            end
        end
    endfunction

    task automatic wait_ready(output int rc);
        int n = 0;
        @(negedge clk);
        while (!o_char_ready_h && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!o_char_ready_h) begin
            check("ready_timeout", 0, 1);
            rc = -1;
        end else begin
            rc = cyc;
        end
    endtask

    task automatic send(input logic [7:0] c, output int acc);
        ch  = c;
        vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        vld = 1'b0;
        ch  = 8'($urandom);
    endtask

    task automatic txn(input logic [7:0] c);
        int acc, busy, rc, bad;
        wq.delete();
        send(c, acc);
        model(c, busy);
        wait_ready(rc);
        check("ready_latency", rc - acc, busy);
        check("write_count", wq.size(), eq.size());
        bad = 0;
        for (int i = 0; i < eq.size() && i < wq.size(); i++)
            if (wq[i].a != eq[i].a || wq[i].d != eq[i].d || wq[i].c - acc != eq[i].c) bad++;
        check("write_list", bad, 0);
        check("cur_x", o_cur_x, mx);
        check("cur_y", o_cur_y, my);
    endtask

    task automatic do_reset();
        int rc, bad;
        rst = 1'b1;
        vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_we", o_we_en_h, 0);
        check("rst_ready", o_char_ready_h, 0);
        check("rst_addr", o_addr_we, 0);
        check("rst_data", o_d_we, 0);
        check("rst_cursor", {o_cur_x, o_cur_y}, 0);
        wq.delete();
        rst = 1'b0;
        wait_ready(rc);
        check("clr_count", wq.size(), TOTAL);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i].a != i || wq[i].d != 32 || (i > 0 && wq[i].c != wq[i-1].c + 1)) bad++;
        check("clr_order", bad, 0);
        check("clr_cur_x", o_cur_x, 0);
        check("clr_cur_y", o_cur_y, 0);
        mx = 0;
        my = 0;
    endtask

    initial begin
        int acc, busy, rc;
        vt[0] = '{8'h41,  1, 0,  1,   0, 8'h41};
        vt[1] = '{8'h42,  2, 0,  1,   1, 8'h42};
        vt[2] = '{8'h08,  1, 0,  1,   1, 8'h20};
        vt[3] = '{8'h0D,  0, 0,  0,   0, 0};
        vt[4] = '{8'h08,  0, 0,  0,   0, 0};
        vt[5] = '{8'h0A,  0, 1, 80,  80, 8'h20};
        vt[6] = '{8'h07,  0, 1,  0,   0, 0};
        vt[7] = '{8'h7A,  1, 1,  1,  80, 8'h7A};
        vt[8] = '{8'hFF,  2, 1,  1,  81, 8'hFF};
        vt[9] = '{8'h0A,  0, 2, 80, 160, 8'h20};

        @(negedge clk);
        do_reset();

        foreach (vt[i]) begin
            txn(vt[i].ch);
            check("tbl_x", o_cur_x, vt[i].ex);
            check("tbl_y", o_cur_y, vt[i].ey);
            check("tbl_nwr", wq.size(), vt[i].nwr);
            if (vt[i].nwr > 0) begin
                check("tbl_addr", wq[0].a, vt[i].fa);
                check("tbl_data", wq[0].d, vt[i].fd);
            end
        end

        // Backspace mid-row, CR, then backspace at column 0.
        for (int i = 0; i < 5; i++) txn(8'h61);
        txn(8'h08);
        check("bs_addr", wq.size() > 0 ? wq[0].a : -1, 164);
        check("bs_cur_x", o_cur_x, 4);
        txn(8'h0D);
        check("cr_nwr", wq.size(), 0);
        txn(8'h08);
        check("bs0_nwr", wq.size(), 0);
        check("bs0_cur", {o_cur_x, o_cur_y}, {7'd0, 5'd2});

        // Wrap from the last column of row 3.
        txn(8'h0A);
        for (int i = 0; i < COLS - 1; i++) txn(8'h62);
        check("pre_wrap_x", o_cur_x, 79);
        txn(8'h5A);
        check("wrap_addr", wq.size() > 0 ? wq[0].a : -1, 319);
        check("wrap_data", wq.size() > 0 ? wq[0].d : -1, 8'h5A);
        check("wrap_last", wq.size() > 80 ? wq[80].a : -1, 399);
        check("wrap_cur", {o_cur_x, o_cur_y}, {7'd0, 5'd4});

        // Linefeed from the bottom row wraps to row 0 and clears it.
        for (int i = 0; i < 20; i++) txn(8'h0A);
        check("bottom_y", o_cur_y, 24);
        txn(8'h0A);
        check("lf_wrap_first", wq.size() > 0 ? wq[0].a : -1, 0);
        check("lf_wrap_last", wq.size() > 79 ? wq[79].a : -1, 79);
        check("lf_wrap_y", o_cur_y, 0);

        // Valid held across the busy cycle: exactly one accept.
        wq.delete();
        ch  = 8'h51;
        vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ch = 8'h52;
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        model(8'h51, busy);
        wait_ready(rc);
        check("hold_nwr", wq.size(), 1);
        check("hold_data", wq.size() > 0 ? wq[0].d : -1, 8'h51);
        check("hold_x", o_cur_x, mx);

        // Form feed mid stream.
        txn(8'h43);
        txn(8'h0C);
        txn(8'h44);

        for (int k = 0; k < 250; k++) begin
            int r;
            logic [7:0] c;
            r = $urandom_range(0, 99);
            if (r < 60)      c = 8'($urandom_range(32, 255));
            else if (r < 72) c = 8'h0A;
            else if (r < 80) c = 8'h0D;
            else if (r < 92) c = 8'h08;
            else if (r < 94) c = 8'h0C;
            else             c = 8'($urandom_range(0, 31));
            txn(c);
        end

        // Reset in the middle of a row clear.
        wq.delete();
        send(8'h0A, acc);
        repeat (10) @(negedge clk);
        check("midclr_started", wq.size() > 5, 1);
        do_reset();
        txn(8'h45);

        check("protocol_invariants", viol, 0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule
